shift_seq_32b: RTL and testbench
================================

# shift_seq_32b

Multi-cycle 32-bit bit-serial shift sequencer that sits directly upstream of the row of 1-bit left/right/no-shift cells in the shifter datapath. It accepts a shift request over a valid/ready handshake and steps the word one bit position per clock. Each step drives the one-hot per-row controls L_SHIFT/R_SHIFT/NO_SHIFT. It holds the row's word register, generates the boundary fill bits, and presents the finished result over a second valid/ready handshake.

## Interface
- WIDTH, 32, datapath width in bits
- SHAMT_W, 5, shift-amount width (log2 WIDTH)

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- RESET_N  input  1  synchronous, active-low reset
- IN_VALID  input  1  request valid
- IN_READY  output  1  block can accept a request
- DATA_IN  input  WIDTH  operand
- SHAMT  input  SHAMT_W  shift amount, 0..WIDTH-1
- DIR  input  1  1 = left, 0 = right
- MODE  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer takes result
- DATA_OUT  output  WIDTH  result word; always equals the internal word register
- L_SHIFT, R_SHIFT, NO_SHIFT  output  1 each  one-hot row controls
- BUSY  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - IN_READY=1 and NO_SHIFT=1.
  - On IN_VALID&IN_READY, latch DATA_IN into the word register and latch SHAMT, DIR and MODE.
  - Go to DONE if SHAMT==0, otherwise go to SHIFT with count=SHAMT.
- SHIFT:
  - Exactly one of L_SHIFT (DIR=1) or R_SHIFT (DIR=0) is high.
  - Each edge updates the word, `next[i] = L ? w[i-1] : R ? w[i+1] : w[i]`, and decrements count.
  - When count==1 at the edge, go to DONE.
- Boundary fill:
  - Left shift: bit0 gets w[WIDTH-1] for rotate, else 0. Arithmetic left behaves as logical left.
  - Right shift: bit WIDTH-1 gets w[0] for rotate, w[WIDTH-1] for arithmetic, else 0.
- DONE:
  - OUT_VALID=1, NO_SHIFT=1, IN_READY=0.
  - DATA_OUT holds stable until OUT_VALID&OUT_READY, then go to IDLE.
- Controls are one-hot in every state. NO_SHIFT=1 in IDLE and DONE.
- IN_READY=1 only in IDLE, so a new request is never accepted in the same cycle as result handoff.
- Inputs are ignored outside IDLE. Latched MODE/DIR/SHAMT cannot change mid-operation.

## Timing
- Reset (RESET_N low at an edge):
  - State goes to IDLE; word, count and latched fields go to 0.
  - Values at the next cycle: OUT_VALID=0, BUSY=0, IN_READY=1, NO_SHIFT=1, L_SHIFT=R_SHIFT=0, DATA_OUT=0.
  - While RESET_N is low, IN_VALID is ignored.
- Reset mid-SHIFT or in DONE aborts the operation; the result is discarded and no OUT_VALID pulse occurs.
- Latency: with acceptance at edge E0, the shifts occur at edges E1..E_SHAMT and OUT_VALID rises in the cycle after E_SHAMT.
  - SHAMT=0: OUT_VALID is high in the cycle right after E0.
- Throughput: one operation per SHAMT+2 cycles, assuming OUT_READY is held high.
- OUT_READY held low leaves the block in DONE indefinitely with all outputs frozen.
- All outputs are decoded from registered state only; there is no combinational path from any input to any output.

## Test plan
- Reset then idle:
  - Hold RESET_N=0 for 2 cycles with IN_VALID=1.
  - Required: IN_READY=1, OUT_VALID=0, NO_SHIFT=1 and DATA_OUT=0 after release; no request was accepted during reset.
- Logical left, SHAMT=4, DATA_IN=0x8000_00F1:
  - L_SHIFT is high for exactly 4 cycles.
  - OUT_VALID rises 5 cycles after acceptance with DATA_OUT=0x0000_0F10.
- Arithmetic right, SHAMT=31, DATA_IN=0x8000_0000: DATA_OUT=0xFFFF_FFFF. The same request with MODE=00 gives 0x0000_0001.
- Rotate right 8, DATA_IN=0x1234_5678: DATA_OUT=0x7812_3456. Rotate left 8 gives 0x3456_7812.
- SHAMT=0 with OUT_READY held low for 3 cycles:
  - OUT_VALID is high the cycle after acceptance, and DATA_OUT=DATA_IN stays stable for all 3 stall cycles.
  - IN_READY=0 throughout; it returns to 1 the cycle after the handshake.
- Reset asserted in the middle of a SHAMT=10 shift:
  - Controls return to NO_SHIFT, DATA_OUT=0 and OUT_VALID never asserts.
  - A subsequent request completes correctly.

Source files
------------

// File: rtl/shift_seq_32b_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_32b_if
// Brief    : Request/result handshake bundle and row controls for shift_seq_32b
// Revision : 1.0
// ============================================================================
interface shift_seq_32b_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               dir;
    logic [1:0]         mode;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    logic               l_shift;
    logic               r_shift;
    logic               no_shift;
    logic               busy;

    modport master (
        output in_valid, data_in, shamt, dir, mode, out_ready,
        input  in_ready, out_valid, data_out, l_shift, r_shift, no_shift, busy
    );

    modport slave (
        input  in_valid, data_in, shamt, dir, mode, out_ready,
        output in_ready, out_valid, data_out, l_shift, r_shift, no_shift, busy
    );
endinterface
`default_nettype wire

// File: rtl/shift_seq_32b.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_32b
// Brief    : Bit-serial shift sequencer, one bit position per clock
// Revision : 1.0
// ============================================================================
module shift_seq_32b #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic    clk,
    input  wire logic    reset_n,
    shift_seq_32b_if.slave bus
);
    localparam logic [1:0] c_mode_arith  = 2'b01;
    localparam logic [1:0] c_mode_rotate = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_word;
    logic [SHAMT_W-1:0] r_count;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_l_shift;
    logic               r_r_shift;
    logic               r_no_shift;
    logic               r_busy;

    logic               w_fill_l;
    logic               w_fill_r;
    logic [WIDTH-1:0]   w_left;
    logic [WIDTH-1:0]   w_right;
    logic [WIDTH-1:0]   w_next;

    // Arithmetic left is deliberately identical to logical left (zero fill).
    assign w_fill_l = (r_mode == c_mode_rotate) ? r_word[WIDTH-1] : 1'b0;
    assign w_fill_r = (r_mode == c_mode_rotate) ? r_word[0]       :
                      (r_mode == c_mode_arith)  ? r_word[WIDTH-1] : 1'b0;

    assign w_left  = {r_word[WIDTH-2:0], w_fill_l};
    assign w_right = {w_fill_r, r_word[WIDTH-1:1]};

    // One 1-bit cell per row position, steered by the registered controls.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_next[i] = r_l_shift ? w_left[i] :
                           r_r_shift ? w_right[i] : r_word[i];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_count     <= '0;
            r_dir       <= 1'b0;
            r_mode      <= 2'b00;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_l_shift   <= 1'b0;
            r_r_shift   <= 1'b0;
            r_no_shift  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_word     <= bus.data_in;
                        r_count    <= bus.shamt;
                        r_dir      <= bus.dir;
                        r_mode     <= bus.mode;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (bus.shamt == '0) begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= S_SHIFT;
                            r_l_shift  <= bus.dir;
                            r_r_shift  <= ~bus.dir;
                            r_no_shift <= 1'b0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_word  <= w_next;
                    r_count <= r_count - 1'b1;
                    if (r_count == SHAMT_W'(1)) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_l_shift   <= 1'b0;
                        r_r_shift   <= 1'b0;
                        r_no_shift  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_l_shift   <= 1'b0;
                    r_r_shift   <= 1'b0;
                    r_no_shift  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.data_out  = r_word;
    assign bus.l_shift   = r_l_shift;
    assign bus.r_shift   = r_r_shift;
    assign bus.no_shift  = r_no_shift;
    assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_shift_seq_32b.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_32b
// Brief    : Directed and random self-checking bench for shift_seq_32b
// Revision : 1.0
// ============================================================================
module tb_shift_seq_32b;
    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    shift_seq_32b_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

    shift_seq_32b #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference result computed directly from the shift definitions.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                              input logic dr, input logic [1:0] m);
        logic [63:0] dd;
        dd = {d, d};
        if (m == 2'b10) begin
            if (dr) begin
                dd = dd << s;
                return dd[63:32];
            end
            dd = dd >> s;
            return dd[31:0];
        end
        if (dr)           return d << s;
        if (m == 2'b01)   return 32'($signed(d) >>> s);
        return d >> s;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] d, input logic [4:0] s,
                        input logic dr, input logic [1:0] m);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.data_in  = d;
        bus.shamt    = s;
        bus.dir      = dr;
        bus.mode     = m;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.data_in  = $urandom;
        bus.shamt    = 5'($urandom);
        bus.dir      = 1'($urandom);
        bus.mode     = 2'($urandom);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic dr, input logic [1:0] m, input int stall);
        int k, lc, rc, bad;
        logic [31:0] exp, held;
        exp = ref_shift(d, int'(s), dr, m);
        send(d, s, dr, m);
        k = 1; lc = 0; rc = 0; bad = 0;
        while (!bus.out_valid && k < 40) begin
            if (32'(bus.l_shift) + 32'(bus.r_shift) + 32'(bus.no_shift) != 1) bad++;
            if (bus.in_ready || !bus.busy) bad++;
            lc += int'(bus.l_shift);
            rc += int'(bus.r_shift);
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'(s) + 32'd1);
        chk({tag, "_l_cycles"}, 32'(lc), dr ? 32'(s) : 32'd0);
        chk({tag, "_r_cycles"}, 32'(rc), dr ? 32'd0 : 32'(s));
        chk({tag, "_ctrl"}, 32'(bad), 32'd0);
        chk({tag, "_data"}, bus.data_out, exp);
        held = bus.data_out;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_valid"}, {bus.out_valid, bus.no_shift, bus.in_ready}, 32'b110);
            chk({tag, "_stall_data"}, bus.data_out, held);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_release"}, {bus.in_ready, bus.out_valid, bus.busy, bus.no_shift}, 32'b1001);
    endtask

    initial begin
        int outs;
        logic [31:0] rd;
        checks   = 0;
        failures = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in   = 32'hDEAD_BEEF;
        bus.shamt     = 5'd3;
        bus.dir       = 1'b1;
        bus.mode      = 2'b00;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hold_data", bus.data_out, 32'd0);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_outs", {bus.out_valid, bus.busy, bus.l_shift, bus.r_shift, bus.no_shift}, 32'b00001);
        chk("reset_data", bus.data_out, 32'd0);

        run_op("lsl4", 32'h8000_00F1, 5'd4, 1'b1, 2'b00, 0);
        chk("lsl4_value", ref_shift(32'h8000_00F1, 4, 1'b1, 2'b00), 32'h0000_0F10);
        run_op("asr31", 32'h8000_0000, 5'd31, 1'b0, 2'b01, 0);
        chk("asr31_value", bus.data_out, 32'hFFFF_FFFF);
        run_op("lsr31", 32'h8000_0000, 5'd31, 1'b0, 2'b00, 0);
        chk("lsr31_value", bus.data_out, 32'h0000_0001);
        run_op("ror8", 32'h1234_5678, 5'd8, 1'b0, 2'b10, 0);
        chk("ror8_value", bus.data_out, 32'h7812_3456);
        run_op("rol8", 32'h1234_5678, 5'd8, 1'b1, 2'b10, 0);
        chk("rol8_value", bus.data_out, 32'h3456_7812);
        run_op("asl5", 32'hC000_0003, 5'd5, 1'b1, 2'b01, 1);
        chk("asl5_value", bus.data_out, 32'h0000_0060);
        run_op("rsv_r3", 32'h8000_0010, 5'd3, 1'b0, 2'b11, 0);
        chk("rsv_r3_value", bus.data_out, 32'h1000_0002);
        run_op("zero_stall", 32'hCAFE_F00D, 5'd0, 1'b0, 2'b10, 3);
        chk("zero_stall_value", bus.data_out, 32'hCAFE_F00D);

        // Reset in the middle of a 10-step shift must discard the operation.
        send(32'hA5A5_0F0F, 5'd10, 1'b1, 2'b00);
        repeat (3) @(negedge clk);
        chk("mid_shift_active", 32'(bus.l_shift), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_reset_outs", {bus.in_ready, bus.out_valid, bus.busy, bus.l_shift, bus.r_shift, bus.no_shift}, 32'b100001);
        chk("mid_reset_data", bus.data_out, 32'd0);
        outs = 0;
        for (int i = 0; i < 15; i++) begin
            outs += int'(bus.out_valid);
            @(negedge clk);
        end
        chk("mid_reset_no_valid", 32'(outs), 32'd0);
        run_op("post_reset", 32'h0F0F_1234, 5'd6, 1'b0, 2'b01, 0);

        for (int n = 0; n < 12; n++) begin
            rd = $urandom;
            run_op("rand", rd, 5'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
